mux4_2b_sync: RTL and testbench

//  2-bit-wide 4:1 multiplexer with bit-level operand ports. Combinational output E selects A/B/C/D by {s1,s0}.

---
 rtl/mux4_2b_sync.sv | 80 ++++++++
 tb/tb_mux4_2b_sync.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mux4_2b_sync.sv
// 2-bit 4:1 select leaf with registered copy and a
// cycle-registered cross-check of behavioural vs gate-level paths.
module mux4_2b_sync #(
  parameter logic [1:0] RST_VAL = 2'b00
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a1,
  input  logic a0,
  input  logic b1,
  input  logic b0,
  input  logic c1,
  input  logic c0,
  input  logic d1,
  input  logic d0,
  input  logic s1,
  input  logic s0,
  output logic e1,
  output logic e0,
  output logic e1_q,
  output logic e0_q,
  output logic mismatch
);

  logic [1:0] a;
  logic [1:0] b;
  logic [1:0] c;
  logic [1:0] d;
  logic [1:0] e_b;
  logic [1:0] e_s;
  logic [1:0] e_q;
  logic       mis_q;
  logic       sel_a;
  logic       sel_b;
  logic       sel_c;
  logic       sel_d;

  assign a = {a1, a0};
  assign b = {b1, b0};
  assign c = {c1, c0};
  assign d = {d1, d0};

  assign sel_a = ~s1 & ~s0;
  assign sel_b = ~s1 &  s0;
  assign sel_c =  s1 & ~s0;
  assign sel_d =  s1 &  s0;

  always_comb begin
    e_b = 2'b00;
    unique case (1'b1)
      sel_a: e_b = a;
      sel_b: e_b = b;
      sel_c: e_b = c;
      sel_d: e_b = d;
    endcase
  end

  // Independent AND-OR path, kept free of procedural code
  assign e_s = ({2{sel_a}} & a)
             | ({2{sel_b}} & b)
             | ({2{sel_c}} & c)
             | ({2{sel_d}} & d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q   <= RST_VAL;
      mis_q <= 1'b0;
    end else begin
      e_q   <= e_b;
      mis_q <= |(e_b ^ e_s);
    end
  end

  assign e1       = e_b[1];
  assign e0       = e_b[0];
  assign e1_q     = e_q[1];
  assign e0_q     = e_q[0];
  assign mismatch = mis_q;

endmodule

// File: tb/tb_mux4_2b_sync.sv
// Directed + exhaustive bench for mux4_2b_sync;
// registered outputs checked through an expectation queue.
module tb_mux4_2b_sync;

  logic       clk;
  logic       rst_n;
  logic [1:0] a;
  logic [1:0] b;
  logic [1:0] c;
  logic [1:0] d;
  logic [1:0] s;
  logic       e1;
  logic       e0;
  logic       e1_q;
  logic       e0_q;
  logic       mismatch;

  int passes = 0;
  int total  = 0;
  logic [1:0] exp_q[$];

  mux4_2b_sync #(.RST_VAL(2'b00)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .a1(a[1]),
    .a0(a[0]),
    .b1(b[1]),
    .b0(b[0]),
    .c1(c[1]),
    .c0(c[0]),
    .d1(d[1]),
    .d0(d[0]),
    .s1(s[1]),
    .s0(s[0]),
    .e1(e1),
    .e0(e0),
    .e1_q(e1_q),
    .e0_q(e0_q),
    .mismatch(mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] model(
    input logic [1:0] sel,
    input logic [1:0] va,
    input logic [1:0] vb,
    input logic [1:0] vc,
    input logic [1:0] vd
  );
    case (sel)
      2'b00:   return va;
      2'b01:   return vb;
      2'b10:   return vc;
      default: return vd;
    endcase
  endfunction

  task automatic chk(
    input string      tag,
    input logic [1:0] obs,
    input logic [1:0] exp
  );
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %b want %b", tag, obs, exp);
  endtask

  // Drive, check comb output, push expectation, then
  // step one edge and check the registered outputs.
  task automatic cycle(
    input string      tag,
    input logic [1:0] ns,
    input logic [1:0] na,
    input logic [1:0] nb,
    input logic [1:0] nc,
    input logic [1:0] nd
  );
    logic [1:0] ex;
    s = ns;
    a = na;
    b = nb;
    c = nc;
    d = nd;
    #1;
    ex = model(ns, na, nb, nc, nd);
    chk({tag, "_e"}, {e1, e0}, ex);
    exp_q.push_back(ex);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "_qempty"}, 2'b00, 2'b11);
    end else begin
      chk({tag, "_eq"}, {e1_q, e0_q}, exp_q.pop_front());
    end
    chk({tag, "_mis"}, {1'b0, mismatch}, 2'b00);
  endtask

  initial begin
    rst_n = 1'b1;
    a = 2'b00;
    b = 2'b01;
    c = 2'b10;
    d = 2'b11;
    s = 2'b00;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_eq", {e1_q, e0_q}, 2'b00);
    chk("rst_mis", {1'b0, mismatch}, 2'b00);
    chk("rst_e", {e1, e0}, 2'b00);
    @(posedge clk);
    #1;
    chk("rst_hold", {e1_q, e0_q}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++)
      cycle("sel", 2'(i), 2'b00, 2'b01, 2'b10, 2'b11);

    for (int i = 0; i < 64; i++)
      cycle("unsel", 2'b10, 2'(i), 2'(i >> 2), 2'b10, 2'(i >> 4));
    cycle("c_chg", 2'b10, 2'b11, 2'b11, 2'b01, 2'b11);

    cycle("pre_rst", 2'b11, 2'b00, 2'b01, 2'b10, 2'b11);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_eq", {e1_q, e0_q}, 2'b00);
    chk("arst_mis", {1'b0, mismatch}, 2'b00);
    chk("arst_e", {e1, e0}, 2'b11);
    @(posedge clk);
    #1;
    chk("arst_hold", {e1_q, e0_q}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arel_eq", {e1_q, e0_q}, 2'b00);
    exp_q.push_back(2'b11);
    @(posedge clk);
    #1;
    chk("arel_cap", {e1_q, e0_q}, exp_q.pop_front());

    for (int i = 0; i < 1024; i++)
      cycle("exh", 2'(i >> 8), 2'(i), 2'(i >> 2), 2'(i >> 4), 2'(i >> 6));

    total++;
    assert (exp_q.size() == 0) passes++;
    else $error("FAIL q_drain: got %0d want 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
